// File: rtl/ram_loader.sv
// Byte-stream loader in front of a single-port RAM; passes CPU accesses through when idle.
// Optional: define RAM_LOADER_CHECKSUM_EN to add a running byte checksum output.
module ram_loader #(
  parameter int unsigned addr_width = 8,
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width-1:0] len,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  input  logic [addr_width-1:0] cpu_addr,
  input  logic [data_width-1:0] cpu_din,
  input  logic                  cpu_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  output logic                  ram_we
`ifdef RAM_LOADER_CHECKSUM_EN
  ,
  output logic [data_width-1:0] checksum
`endif
);

  // One extra bit so that len=0 can be held as 2^addr_width
  localparam int unsigned cnt_w = addr_width + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } state_t;

  state_t                  state;
  logic [addr_width-1:0]   ptr;
  logic [cnt_w-1:0]        remaining;
  logic                    wr_pend;
  logic [data_width-1:0]   wdata;
  logic                    transfer;

  assign in_ready = (state == LOAD) && (remaining != '0);
  assign busy     = (state != IDLE);
  assign transfer = in_valid && in_ready;

  // RAM port mux: CPU owns the RAM only while idle
  always_comb begin
    ram_addr = ptr;
    ram_din  = wdata;
    ram_we   = wr_pend;
    if (state == IDLE) begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = cpu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      wr_pend   <= 1'b0;
      wdata     <= '0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      wr_pend <= transfer;
      if (wr_pend) begin
        ptr <= ptr + addr_width'(1);
      end
      if (transfer) begin
        wdata     <= in_data;
        remaining <= remaining - cnt_w'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            ptr       <= base_addr;
            remaining <= (len == '0) ? {1'b1, {addr_width{1'b0}}} : {1'b0, len};
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (transfer && remaining == cnt_w'(1)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_LOADER_CHECKSUM_EN
  // Running modulo sum of accepted bytes, restarted by each accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (transfer) begin
      checksum <= checksum + in_data;
    end
  end
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural RAM attached to the ram_* port.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, cpu_we;
  logic [7:0] base_addr, len, in_data, cpu_addr, cpu_din;
  logic       in_ready, busy, done, ram_we;
  logic [7:0] ram_addr, ram_din;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  logic [7:0] mem [256];

  ram_loader #(.addr_width(8), .data_width(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .done(done), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we)
`ifdef RAM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Downstream RAM model plus write and done-pulse counters
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    base_addr = 8'h00; len = 8'h00; cpu_addr = 8'h07; cpu_din = 8'h09; cpu_we = 1'b0;
    tick; tick;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({busy, in_ready, done, ram_we} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy/rdy/done/we=%b want 0000", {busy, in_ready, done, ram_we});
    end
    tests_run++;
    if (ram_addr !== 8'h07 || ram_din !== 8'h09) begin
      tests_failed++;
      $display("FAIL reset_passthru: got addr=%h din=%h want 07 09", ram_addr, ram_din);
    end
  endtask

  task automatic test_passthrough;
    cpu_addr = 8'd3; cpu_din = 8'd11; cpu_we = 1'b1;
    #1;
    tests_run++;
    if ({ram_addr, ram_din, ram_we} !== {8'd3, 8'd11, 1'b1}) begin
      tests_failed++;
      $display("FAIL passthru: got addr=%h din=%h we=%b want 03 0b 1", ram_addr, ram_din, ram_we);
    end
    tick;
    cpu_we = 1'b0;
    tick;
    tests_run++;
    if (mem[3] !== 8'd11 || busy !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL passthru_mem: got mem3=%h busy=%b rdy=%b want 0b 0 0", mem[3], busy, in_ready);
    end
  endtask

  task automatic test_basic;
    int d0, w0;
    d0 = done_cnt; w0 = wr_cnt;
    start = 1'b1; base_addr = 8'h10; len = 8'd4;
    tick;
    start = 1'b0;
    tests_run++;
    if ({busy, in_ready, ram_we} !== 3'b110) begin
      tests_failed++;
      $display("FAIL basic_enter: got busy/rdy/we=%b want 110", {busy, in_ready, ram_we});
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hA1 + i);
      tick;
      tests_run++;
      if ({ram_we, ram_addr, ram_din} !== {1'b1, 8'(8'h10 + i), 8'(8'hA1 + i)}) begin
        tests_failed++;
        $display("FAIL basic_write%0d: got we=%b addr=%h din=%h want 1 %h %h",
                 i, ram_we, ram_addr, ram_din, 8'(8'h10 + i), 8'(8'hA1 + i));
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if ({busy, in_ready, done} !== 3'b100) begin
      tests_failed++;
      $display("FAIL basic_flush: got busy/rdy/done=%b want 100", {busy, in_ready, done});
    end
    tick;
    tests_run++;
    if ({busy, done, ram_we} !== 3'b010) begin
      tests_failed++;
      $display("FAIL basic_done: got busy/done/we=%b want 010", {busy, done, ram_we});
    end
    tick;
    tests_run++;
    if (done !== 1'b0 || done_cnt - d0 != 1 || wr_cnt - w0 != 4) begin
      tests_failed++;
      $display("FAIL basic_counts: got done=%b pulses=%0d writes=%0d want 0 1 4",
               done, done_cnt - d0, wr_cnt - w0);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[8'(8'h10 + i)] !== 8'(8'hA1 + i)) begin
        tests_failed++;
        $display("FAIL basic_mem%0d: got %h want %h", i, mem[8'(8'h10 + i)], 8'(8'hA1 + i));
      end
    end
`ifdef RAM_LOADER_CHECKSUM_EN
    tests_run++;
    if (checksum !== 8'h8A) begin
      tests_failed++;
      $display("FAIL basic_checksum: got %h want 8a", checksum);
    end
`endif
  endtask

  task automatic test_stall;
    logic [7:0] s5;
    int k;
    s5 = mem[5];
    cpu_addr = 8'h05; cpu_din = 8'hEE;
    start = 1'b1; base_addr = 8'h20; len = 8'd3;
    tick;
    start = 1'b0; cpu_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h31 + i);
      tick;
      if (i == 2) cpu_we = 1'b0;
      tests_run++;
      if (ram_we !== 1'b1 || ram_addr !== 8'(8'h20 + i)) begin
        tests_failed++;
        $display("FAIL stall_write%0d: got we=%b addr=%h want 1 %h", i, ram_we, ram_addr, 8'(8'h20 + i));
      end
      in_valid = 1'b0;
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          tick;
          tests_run++;
          if (ram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_gap%0d_%0d: got we=%b want 0", i, g, ram_we);
          end
        end
      end
    end
    k = 0;
    while (done !== 1'b1 && k < 8) begin tick; k++; end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_done: got done=%b want 1 within 8 cycles", done);
    end
    tick;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mem[8'(8'h20 + i)] !== 8'(8'h31 + i)) begin
        tests_failed++;
        $display("FAIL stall_mem%0d: got %h want %h", i, mem[8'(8'h20 + i)], 8'(8'h31 + i));
      end
    end
    tests_run++;
    if (mem[5] !== s5) begin
      tests_failed++;
      $display("FAIL stall_cpu_gate: got mem5=%h want %h", mem[5], s5);
    end
  endtask

  task automatic test_wrap;
    int k;
    logic [7:0] a;
    start = 1'b1; base_addr = 8'hFE; len = 8'd3;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1);
      tick;
    end
    in_valid = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 8) begin tick; k++; end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_done: got done=%b want 1", done);
    end
    tick;
    for (int i = 0; i < 3; i++) begin
      a = 8'(8'hFE + i);
      tests_run++;
      if (mem[a] !== 8'(i + 1)) begin
        tests_failed++;
        $display("FAIL wrap_mem%0d: addr %h got %h want %h", i, a, mem[a], 8'(i + 1));
      end
    end
`ifdef RAM_LOADER_CHECKSUM_EN
    tests_run++;
    if (checksum !== 8'h06) begin
      tests_failed++;
      $display("FAIL wrap_checksum: got %h want 06", checksum);
    end
`endif
  endtask

  task automatic test_len0;
    int cnt, k, d0;
    d0 = done_cnt;
    start = 1'b1; base_addr = 8'h00; len = 8'h00;
    tick;
    start = 1'b0;
    cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (in_ready !== 1'b1) break;
      in_data = 8'(cnt);
      cnt++;
      tick;
    end
    in_valid = 1'b0;
    tests_run++;
    if (cnt != 256) begin
      tests_failed++;
      $display("FAIL len0_count: got %0d transfers want 256", cnt);
    end
    k = 0;
    while (done !== 1'b1 && k < 8) begin tick; k++; end
    tick;
    tests_run++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL len0_done: got pulses=%0d busy=%b want 1 0", done_cnt - d0, busy);
    end
    tests_run++;
    if (mem[8'h00] !== 8'h00 || mem[8'h7F] !== 8'h7F || mem[8'hFF] !== 8'hFF) begin
      tests_failed++;
      $display("FAIL len0_mem: got %h %h %h want 00 7f ff", mem[8'h00], mem[8'h7F], mem[8'hFF]);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] s42, s43, s44;
    int d0;
    s42 = mem[8'h42]; s43 = mem[8'h43]; s44 = mem[8'h44];
    d0 = done_cnt;
    start = 1'b1; base_addr = 8'h40; len = 8'd5;
    tick;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h51;
    tick;
    in_data = 8'h52;
    tick;
    rst = 1'b1; in_data = 8'h53;
    tick;
    rst = 1'b0;
    tests_run++;
    if ({ram_we, busy, in_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rstmid_abort: got we/busy/rdy=%b want 000", {ram_we, busy, in_ready});
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      tests_run++;
      if ({ram_we, done, busy} !== 3'b000) begin
        tests_failed++;
        $display("FAIL rstmid_after%0d: got we/done/busy=%b want 000", i, {ram_we, done, busy});
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (mem[8'h40] !== 8'h51 || mem[8'h41] !== 8'h52) begin
      tests_failed++;
      $display("FAIL rstmid_written: got %h %h want 51 52", mem[8'h40], mem[8'h41]);
    end
    tests_run++;
    if (mem[8'h42] !== s42 || mem[8'h43] !== s43 || mem[8'h44] !== s44 || done_cnt != d0) begin
      tests_failed++;
      $display("FAIL rstmid_untouched: got %h %h %h pulses=%0d want %h %h %h 0",
               mem[8'h42], mem[8'h43], mem[8'h44], done_cnt - d0, s42, s43, s44);
    end
  endtask

  task automatic test_start_ignored;
    logic [7:0] s80;
    int k, d0;
    s80 = mem[8'h80];
    d0 = done_cnt;
    start = 1'b1; base_addr = 8'h60; len = 8'd3;
    tick;
    in_valid = 1'b1; in_data = 8'hC1;
    base_addr = 8'h80; len = 8'd1;
    tick;
    start = 1'b0; in_data = 8'hC2;
    tick;
    in_data = 8'hC3;
    tick;
    in_valid = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 8) begin tick; k++; end
    tick;
    tests_run++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_done: got pulses=%0d busy=%b want 1 0", done_cnt - d0, busy);
    end
    tests_run++;
    if (mem[8'h60] !== 8'hC1 || mem[8'h61] !== 8'hC2 || mem[8'h62] !== 8'hC3) begin
      tests_failed++;
      $display("FAIL ignore_mem: got %h %h %h want c1 c2 c3", mem[8'h60], mem[8'h61], mem[8'h62]);
    end
    tests_run++;
    if (mem[8'h80] !== s80) begin
      tests_failed++;
      $display("FAIL ignore_80: got %h want %h", mem[8'h80], s80);
    end
`ifdef RAM_LOADER_CHECKSUM_EN
    tests_run++;
    if (checksum !== 8'h46) begin
      tests_failed++;
      $display("FAIL ignore_checksum: got %h want 46", checksum);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_basic;
    test_stall;
    test_wrap;
    test_reset_mid;
    test_start_ignored;
    test_len0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Sequential byte loader that sits directly upstream of the RAM block and drives its addr/din/we inputs.
- Accepts a stream of bytes over a valid/ready handshake from a host port (UART receiver or bench) and writes them to consecutive RAM addresses starting at a given base.
- When idle, it passes CPU-side memory accesses through to the RAM unchanged, so the same RAM serves boot loading and normal execution.

Parameters:
- addr_width, 8, RAM address width; also the width of base_addr, len, ram_addr and cpu_addr.
- data_width, 8, byte width; also the width of in_data, ram_din and cpu_din.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  in  addr_width  first RAM address written; sampled when start is accepted.
- len  in  addr_width  byte count; 0 means 2^addr_width bytes; sampled when start is accepted.
- in_data  in  data_width  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- busy  out  1  high in LOAD and FLUSH.
- done  out  1  one-cycle pulse when the last byte has been written.
- cpu_addr  in  addr_width  CPU address, passed through when not busy.
- cpu_din  in  data_width  CPU write data, passed through when not busy.
- cpu_we  in  1  CPU write enable; gated off while busy.
- ram_addr  out  addr_width  to RAM addr.
- ram_din  out  data_width  to RAM din.
- ram_we  out  1  to RAM we.

Behaviour:
- States:
  - IDLE -> LOAD on start.
  - LOAD -> FLUSH when the final byte is accepted.
  - FLUSH -> IDLE after one cycle, with done=1 during that transition edge's following cycle.
- Reset (posedge with rst=1): state=IDLE; ptr=0; remaining=0; wr_pend=0; done=0. Combinational outputs then give in_ready=0, busy=0, and ram_* = cpu passthrough.
- Start: in IDLE, start=1 at a posedge latches ptr<=base_addr and remaining<=len (0 is loaded as 2^addr_width, so the counter is addr_width+1 bits), then moves to LOAD. start in any other state is ignored.
- Accept: in_ready = (state==LOAD) && remaining!=0. A transfer occurs on a posedge where in_valid && in_ready. On a transfer: wdata<=in_data, wr_pend<=1, remaining decrements.
- Write:
  - While wr_pend=1: ram_addr=ptr, ram_din=wdata, ram_we=1. These hold for a full clock cycle, so both posedge- and negedge-active RAMs capture the write.
  - At the next posedge, ptr<=ptr+1 (wraps modulo 2^addr_width). wr_pend<=1 if another transfer occurs on that edge, else 0.
- Throughput: 1 byte/cycle with in_valid held high. Latency is one cycle from acceptance to ram_we asserted.
- Final byte: the transfer that brings remaining to 0 moves the state to FLUSH, where the final write completes. On the FLUSH->IDLE edge, done<=1 for exactly one cycle.
- Passthrough: in IDLE only, ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we. During LOAD/FLUSH with wr_pend=0: ram_addr=ptr, ram_din=wdata, ram_we=0, and cpu_we is discarded.
- Stalls: in_valid low mid-load simply pauses the transfer. No timeout.
- Reset mid-load aborts immediately: no further write after the reset edge, and no done pulse.

Optional Feature:
- Macro: RAM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - Extra output checksum [data_width-1:0]: modulo-2^data_width sum of all bytes accepted since the last accepted start.
  - Cleared to 0 on reset and on start acceptance; updated on each transfer.
  - Valid and stable from the done pulse until the next start.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle passthrough: cpu_addr=3, cpu_din=11, cpu_we=1 -> ram_addr=3, ram_din=11, ram_we=1 in the same cycle; after the next edges a RAM read at 3 returns 11; busy=0, in_ready=0.
- Basic load: start with base_addr=8'h10, len=4; stream 8'hA1..8'hA4 back-to-back -> writes at 10..13 on consecutive cycles; done pulses once, one cycle after the last write; RAM reads 10..13 return A1..A4; checksum=8'h8A when enabled.
- Stalled stream: base=0x20, len=3, with in_valid low for 2 cycles between bytes -> no ram_we during the gaps; final contents at 20..22 are correct; cpu_we=1 during the load leaves address 0x05 unmodified.
- Wrap and len=0: base=0xFE, len=3, bytes 1,2,3 -> addresses FE, FF, 00. Separately, len=0 -> in_ready stays high for exactly 256 transfers, then done.
- Reset mid-load: base=0x40, len=5; assert rst after 2 transfers -> ram_we=0 from the reset edge on; 0x42..0x44 unchanged; no done pulse; busy=0.
- Start ignored while busy: second start with base=0x80 during a load -> no write to 0x80; the original load completes normally.
